gcn_aggregation: RTL and testbench
==================================

GCN_AGGREGATION -- requirements
Module: gcn_aggregation

Interface
REQ-001 SHALL have parameter FEATURE_ROWS, default 6, number of graph nodes and rows of the transformed matrix.
REQ-002 SHALL have parameter WEIGHT_COLS, default 3, columns per transformed row.
REQ-003 SHALL have parameter DOT_PROD_WIDTH, default 16, width of each matrix element.
REQ-004 SHALL have parameter COO_NUM_OF_COLS, default 6, number of edges in the COO list.
REQ-005 SHALL have parameter COO_BW, default $clog2(COO_NUM_OF_COLS), width of one node index.
REQ-006 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, level run request.
REQ-009 SHALL have port fm_wm_ready, input, 1, upstream feature-x-weight product matrix complete.
REQ-010 SHALL have port fm_wm_row_addr, output, $clog2(FEATURE_ROWS), transformed-row read address.
REQ-011 SHALL have port fm_wm_row_in, input, WEIGHT_COLS x DOT_PROD_WIDTH, row at fm_wm_row_addr, same-cycle combinational.
REQ-012 SHALL have port coo_address, output, COO_BW, edge index into the COO list.
REQ-013 SHALL have port coo_in, input, 2*COO_BW, {src,dst} for coo_address, same-cycle combinational.
REQ-014 SHALL have port agg_out, output, FEATURE_ROWS x WEIGHT_COLS x DOT_PROD_WIDTH, aggregated matrix feeding argmax.
REQ-015 SHALL have port done, output, 1, aggregation complete.
REQ-016 SHALL have port edge_err, output, 1, sticky invalid-node flag.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, INIT (macro only), FETCH, READ_SRC, READ_DST_ACC, DONE.
REQ-018 SHALL leave IDLE only on a rising edge with start=1 and fm_wm_ready=1; otherwise it stays in IDLE.
REQ-019 SHALL zero all agg_out and edge_err in CLEAR, taking 1 cycle.
REQ-020 SHALL, in FETCH, drive coo_address=e and latch src/dst from coo_in; e runs 0..COO_NUM_OF_COLS-1.
REQ-021 SHALL treat COO node values as 1-based; row index = value-1.
REQ-022 SHALL, in READ_SRC, drive fm_wm_row_addr=src-1 and latch the row.
REQ-023 SHALL, in READ_DST_ACC, drive fm_wm_row_addr=dst-1, add row_src into agg_out[dst-1] and add row_dst into agg_out[src-1].
REQ-024 SHALL add once, into agg_out[src-1], when src==dst.
REQ-025 SHALL skip an edge with either value 0 or >FEATURE_ROWS, perform no accumulation for it, and set edge_err.
REQ-026 SHALL wrap sums modulo 2^DOT_PROD_WIDTH, unsigned, with no saturation.
REQ-027 SHALL use 3 cycles per edge; without the macro, CLEAR is cycle 1, edges take cycles 2-19, and done rises on edge 20 after start is sampled.
REQ-028 SHALL hold done=1 and agg_out stable in DONE until start=0, then return to IDLE with done=0 and agg_out retained.
REQ-029 SHALL ignore start changes during a run, including a start deassertion mid-run.
REQ-030 SHALL ignore fm_wm_ready after launch.

Reset
REQ-031 SHALL, on reset=0 at any time including mid-run, force IDLE, agg_out=0, done=0, edge_err=0, coo_address=0, fm_wm_row_addr=0.
REQ-032 SHALL start a new run only after reset deasserts and a fresh start qualifies.

Configuration
REQ-033 SHALL, with GCN_AGG_SELF_LOOP_EN defined, replace CLEAR with INIT, which copies row i into agg_out[i] for i=0..FEATURE_ROWS-1, one row per cycle (cycles 1-6), computing (A+I)·FW; done rises on edge 25.
REQ-034 SHALL, without GCN_AGG_SELF_LOOP_EN, omit INIT logic and compute A·FW.

Structure
REQ-035 SHALL place the state enum, default parameter constants, and the row type (WEIGHT_COLS x DOT_PROD_WIDTH) in shared package gcn_pkg.
REQ-036 SHALL contain one sub-module, gcn_row_adder, a combinational WEIGHT_COLS-lane wrapping adder used twice in READ_DST_ACC.

Verification
REQ-037 SHALL cover the single edge case: edges all {1,2}, row0=(1,2,3), row1=(10,20,30) -> agg_out[0]=(60,120,180), agg_out[1]=(6,12,18), done on edge 20.
REQ-038 SHALL cover the self-loop case: edge {3,3} x6, row2=(5,0,1) -> agg_out[2]=(30,0,6), no double count, other rows 0.
REQ-039 SHALL cover the invalid node case: one edge {0,4} among valid ones -> edge_err=1 and that edge contributes nothing.
REQ-040 SHALL cover wrap-around: edge {1,2} x6, row1=(0xFFFF,...) -> agg_out[0] lane = 0xFFFA.
REQ-041 SHALL cover reset mid-run: reset=0 at cycle 9 -> all outputs 0 within the same cycle; a rerun matches the golden result.
REQ-042 SHALL cover the macro build: the REQ-037 stimulus -> agg_out[0]=(61,122,183), done on edge 25.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and default constants for the GCN aggregation block.
// Optional feature macro: GCN_AGG_SELF_LOOP_EN (replaces CLEAR with INIT,
// seeding the accumulator with the transformed rows so the result is (A+I)*FW).
package gcn_pkg;

  localparam int FEATURE_ROWS_D    = 6;
  localparam int WEIGHT_COLS_D     = 3;
  localparam int DOT_PROD_WIDTH_D  = 16;
  localparam int COO_NUM_OF_COLS_D = 6;

  // One transformed row: WEIGHT_COLS lanes of DOT_PROD_WIDTH bits, lane 0 in the LSBs
  typedef logic [WEIGHT_COLS_D-1:0][DOT_PROD_WIDTH_D-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
`ifdef GCN_AGG_SELF_LOOP_EN
    INIT,
`else
    CLEAR,
`endif
    FETCH,
    READ_SRC,
    READ_DST_ACC,
    DONE
  } state_t;

endpackage

// File: rtl/gcn_row_adder.sv
// Combinational lane-wise adder for one transformed row; each lane wraps
// modulo 2^DOT_PROD_WIDTH (unsigned, no saturation).
module gcn_row_adder
  import gcn_pkg::*;
#(
  parameter int WEIGHT_COLS    = WEIGHT_COLS_D,
  parameter int DOT_PROD_WIDTH = DOT_PROD_WIDTH_D
) (
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] a,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] b,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] sum
);

  // Independent per-lane wrapping sums
  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < WEIGHT_COLS; j++) begin
      sum[j] = a[j] + b[j];
    end
  end

endmodule

// File: rtl/gcn_aggregation.sv
// GCN neighbour aggregation: walks the COO edge list and accumulates, for each
// undirected edge {src,dst} (1-based node ids), row src into dst and row dst
// into src. Self-loops add once; edges naming node 0 or a node beyond
// FEATURE_ROWS are skipped and raise the sticky edge_err flag.
// Optional feature macro: GCN_AGG_SELF_LOOP_EN (INIT seeds agg_out with the
// transformed rows instead of clearing it).
module gcn_aggregation
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS    = FEATURE_ROWS_D,
  parameter int WEIGHT_COLS     = WEIGHT_COLS_D,
  parameter int DOT_PROD_WIDTH  = DOT_PROD_WIDTH_D,
  parameter int COO_NUM_OF_COLS = COO_NUM_OF_COLS_D,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                start,
  input  logic                                                fm_wm_ready,
  output logic [$clog2(FEATURE_ROWS)-1:0]                     fm_wm_row_addr,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]               fm_wm_row_in,
  output logic [COO_BW-1:0]                                   coo_address,
  input  logic [2*COO_BW-1:0]                                 coo_in,
  output logic [FEATURE_ROWS*WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  agg_out,
  output logic                                                done,
  output logic                                                edge_err
);

  localparam int RAW = $clog2(FEATURE_ROWS);

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] lrow_t;

  state_t state, state_nxt;

  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg;
  lrow_t             row_in, row_src, sum_dst, sum_src;
  logic [COO_BW-1:0] src, dst, edge_cnt, coo_src, coo_dst;
  logic [RAW-1:0]    src_idx, dst_idx;
  logic              edge_ok, edge_last;
`ifdef GCN_AGG_SELF_LOOP_EN
  logic [RAW-1:0]    init_cnt;
  logic              init_last;
`endif

  function automatic logic node_ok(input logic [COO_BW-1:0] v);
    return (v != '0) && (32'(v) <= 32'(FEATURE_ROWS));
  endfunction

  assign row_in      = fm_wm_row_in;
  assign agg_out     = agg;
  assign coo_address = edge_cnt;
  assign coo_src     = coo_in[2*COO_BW-1 -: COO_BW];
  assign coo_dst     = coo_in[COO_BW-1:0];
  // Node ids are 1-based; row indices are 0-based
  assign src_idx     = RAW'(src - COO_BW'(1));
  assign dst_idx     = RAW'(dst - COO_BW'(1));
  assign edge_last   = (32'(edge_cnt) == 32'(COO_NUM_OF_COLS - 1));
`ifdef GCN_AGG_SELF_LOOP_EN
  assign init_last   = (32'(init_cnt) == 32'(FEATURE_ROWS - 1));
`endif

  gcn_row_adder #(
    .WEIGHT_COLS    (WEIGHT_COLS),
    .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
  ) u_add_dst (
    .a   (agg[dst_idx]),
    .b   (row_src),
    .sum (sum_dst)
  );

  gcn_row_adder #(
    .WEIGHT_COLS    (WEIGHT_COLS),
    .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
  ) u_add_src (
    .a   (agg[src_idx]),
    .b   (row_in),
    .sum (sum_src)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and row read address
  always_comb begin
    state_nxt      = state;
    fm_wm_row_addr = '0;
    unique case (state)
      IDLE: begin
        if (start && fm_wm_ready) begin
`ifdef GCN_AGG_SELF_LOOP_EN
          state_nxt = INIT;
`else
          state_nxt = CLEAR;
`endif
        end
      end
`ifdef GCN_AGG_SELF_LOOP_EN
      INIT: begin
        fm_wm_row_addr = init_cnt;
        if (init_last) state_nxt = FETCH;
      end
`else
      CLEAR:        state_nxt = FETCH;
`endif
      FETCH:        state_nxt = READ_SRC;
      READ_SRC: begin
        if (edge_ok) fm_wm_row_addr = src_idx;
        state_nxt = READ_DST_ACC;
      end
      READ_DST_ACC: begin
        if (edge_ok) fm_wm_row_addr = dst_idx;
        state_nxt = edge_last ? DONE : FETCH;
      end
      DONE: begin
        if (done && !start) state_nxt = IDLE;
      end
      default:      state_nxt = IDLE;
    endcase
  end

  // Datapath: accumulator, edge latch, error and done flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      agg      <= '0;
      edge_err <= 1'b0;
      done     <= 1'b0;
      edge_cnt <= '0;
      src      <= '0;
      dst      <= '0;
      edge_ok  <= 1'b0;
      row_src  <= '0;
`ifdef GCN_AGG_SELF_LOOP_EN
      init_cnt <= '0;
`endif
    end else begin
      unique case (state)
`ifdef GCN_AGG_SELF_LOOP_EN
        INIT: begin
          agg[init_cnt] <= row_in;
          edge_err      <= 1'b0;
          edge_cnt      <= '0;
          init_cnt      <= init_last ? '0 : init_cnt + RAW'(1);
        end
`else
        CLEAR: begin
          agg      <= '0;
          edge_err <= 1'b0;
          edge_cnt <= '0;
        end
`endif
        FETCH: begin
          src     <= coo_src;
          dst     <= coo_dst;
          edge_ok <= node_ok(coo_src) && node_ok(coo_dst);
          if (!(node_ok(coo_src) && node_ok(coo_dst))) edge_err <= 1'b1;
        end
        READ_SRC:     row_src <= row_in;
        READ_DST_ACC: begin
          // Both sums read the pre-edge accumulator; a self-loop keeps only one write
          if (edge_ok) begin
            agg[dst_idx] <= sum_dst;
            if (src != dst) agg[src_idx] <= sum_src;
          end
          edge_cnt <= edge_last ? '0 : edge_cnt + COO_BW'(1);
        end
        DONE:         done <= !(done && !start);
        default:      ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_aggregation.sv
// Directed bench for gcn_aggregation with a scoreboard of expected rows.
// Honours GCN_AGG_SELF_LOOP_EN for expected latency and seeded rows.
module tb_gcn_aggregation;
  import gcn_pkg::*;

`ifdef GCN_AGG_SELF_LOOP_EN
  localparam int LAT = 25;
`else
  localparam int LAT = 20;
`endif

  logic         clk = 1'b0;
  logic         reset, start, fm_wm_ready;
  logic [2:0]   fm_wm_row_addr;
  logic [47:0]  fm_wm_row_in;
  logic [2:0]   coo_address;
  logic [5:0]   coo_in;
  logic [287:0] agg_out;
  logic         done, edge_err;

  row_t       rows [6];
  logic [2:0] e_src [6];
  logic [2:0] e_dst [6];

  typedef struct { int idx; logic [47:0] val; } exp_t;
  exp_t sbq [$];
  row_t m [6];
  logic merr;

  int checks = 0;
  int errors = 0;

  gcn_aggregation #(
    .FEATURE_ROWS    (6),
    .WEIGHT_COLS     (3),
    .DOT_PROD_WIDTH  (16),
    .COO_NUM_OF_COLS (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fm_wm_ready    (fm_wm_ready),
    .fm_wm_row_addr (fm_wm_row_addr),
    .fm_wm_row_in   (fm_wm_row_in),
    .coo_address    (coo_address),
    .coo_in         (coo_in),
    .agg_out        (agg_out),
    .done           (done),
    .edge_err       (edge_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    fm_wm_row_in = '0;
    coo_in       = '0;
    if (fm_wm_row_addr < 3'd6) fm_wm_row_in = rows[fm_wm_row_addr];
    if (coo_address < 3'd6)    coo_in = {e_src[coo_address], e_dst[coo_address]};
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_edges(input logic [2:0] s [6], input logic [2:0] d [6]);
    for (int i = 0; i < 6; i++) begin
      e_src[i] = s[i];
      e_dst[i] = d[i];
    end
  endtask

  // Reference: undirected accumulation over the edge list, invalid edges skipped
  task automatic model_push();
    for (int i = 0; i < 6; i++) begin
`ifdef GCN_AGG_SELF_LOOP_EN
      m[i] = rows[i];
`else
      m[i] = '0;
`endif
    end
    merr = 1'b0;
    for (int e = 0; e < 6; e++) begin
      int s, d;
      s = int'(e_src[e]);
      d = int'(e_dst[e]);
      if (s == 0 || s > 6 || d == 0 || d > 6) begin
        merr = 1'b1;
      end else begin
        for (int j = 0; j < 3; j++) begin
          m[d-1][j] = m[d-1][j] + rows[s-1][j];
          if (s != d) m[s-1][j] = m[s-1][j] + rows[d-1][j];
        end
      end
    end
    for (int i = 0; i < 6; i++) sbq.push_back('{idx: i, val: m[i]});
    sbq.push_back('{idx: 6, val: {47'b0, merr}});
  endtask

  task automatic run_case(input string tag, input bit disturb);
    int lat;
    bit got;
    exp_t x;
    model_push();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (disturb && lat == 3) fm_wm_ready = 1'b0;
      if (disturb && lat == 5) start = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    check($sformatf("%s_latency", tag), 48'(lat), 48'(LAT));
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      if (x.idx < 6) check($sformatf("%s_row%0d", tag, x.idx), agg_out[x.idx*48 +: 48], x.val);
      else           check($sformatf("%s_edge_err", tag), {47'b0, edge_err}, x.val);
    end
    if (!disturb) begin
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("%s_done_hold", tag), {47'b0, done}, 48'd1);
    end
    @(negedge clk);
    start = 1'b0;
    fm_wm_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s_done_low", tag), {47'b0, done}, 48'd0);
    check($sformatf("%s_retained", tag), agg_out[47:0], m[0]);
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 6; i++) check($sformatf("%s_agg%0d", tag, i), agg_out[i*48 +: 48], 48'd0);
    check($sformatf("%s_done", tag), {47'b0, done}, 48'd0);
    check($sformatf("%s_err", tag), {47'b0, edge_err}, 48'd0);
    check($sformatf("%s_coo", tag), {45'b0, coo_address}, 48'd0);
    check($sformatf("%s_raddr", tag), {45'b0, fm_wm_row_addr}, 48'd0);
  endtask

  initial begin
    logic [2:0] s12 [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [2:0] d12 [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic [2:0] s33 [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    logic [2:0] sbd [6] = '{3'd1, 3'd0, 3'd2, 3'd5, 3'd4, 3'd6};
    logic [2:0] dbd [6] = '{3'd2, 3'd4, 3'd3, 3'd6, 3'd1, 3'd6};
    row_t exp_a0;

    reset = 1'b0;
    start = 1'b0;
    fm_wm_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) rows[i][j] = 16'(i * 100 + j + 7);
    end
    set_edges(s12, d12);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single repeated edge {1,2}
    rows[0] = {16'd3, 16'd2, 16'd1};
    rows[1] = {16'd30, 16'd20, 16'd10};
    run_case("single", 1'b0);
`ifdef GCN_AGG_SELF_LOOP_EN
    exp_a0 = {16'd183, 16'd122, 16'd61};
`else
    exp_a0 = {16'd180, 16'd120, 16'd60};
`endif
    check("single_row0_const", agg_out[47:0], exp_a0);

    // start without fm_wm_ready must not launch
    @(negedge clk);
    fm_wm_ready = 1'b0;
    start = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("noready_done", {47'b0, done}, 48'd0);
    check("noready_coo", {45'b0, coo_address}, 48'd0);
    check("noready_kept", agg_out[47:0], exp_a0);
    @(negedge clk);
    start = 1'b0;
    fm_wm_ready = 1'b1;

    // Self-loop {3,3}, with start and ready dropped mid-run
    rows[2] = {16'd1, 16'd0, 16'd5};
    set_edges(s33, s33);
    run_case("selfloop", 1'b1);

    // Invalid node among valid edges
    set_edges(sbd, dbd);
    run_case("invalid", 1'b0);

    // Wrap-around
    rows[1] = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    set_edges(s12, d12);
    run_case("wrap", 1'b0);

    // Reset mid-run, then rerun the invalid-edge case
    set_edges(sbd, dbd);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_case("rerun", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
